// File: rtl/cdb_writeback_arbiter.sv
// ============================================================================
// Module      : cdb_writeback_arbiter
// Description : Holds one completed FU result per requester and broadcasts up
//               to NUM_CDB of them per cycle on the CDB in round-robin order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_writeback_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int NUM_CDB       = 2,
    parameter int PHYS_REG_BITS = 6,
    parameter int ROB_BITS      = 4,
    localparam int c_IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*PHYS_REG_BITS-1:0]   req_pd_s,
    input  logic [NUM_REQ*32-1:0]              req_value,
    input  logic [NUM_REQ*ROB_BITS-1:0]        req_rob_num,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [NUM_CDB-1:0]                 cdb_valid,
    output logic [NUM_CDB*PHYS_REG_BITS-1:0]   cdb_pd_s,
    output logic [NUM_CDB*32-1:0]              cdb_value,
    output logic [NUM_CDB*ROB_BITS-1:0]        cdb_rob_num,
    output logic [NUM_CDB*c_IDX_W-1:0]         cdb_src
);

    logic [NUM_REQ-1:0]       r_hold_valid;
    logic [PHYS_REG_BITS-1:0] r_hold_pd_s   [NUM_REQ];
    logic [31:0]              r_hold_value  [NUM_REQ];
    logic [ROB_BITS-1:0]      r_hold_rob    [NUM_REQ];
    logic [c_IDX_W-1:0]       r_rr_ptr;

    logic [NUM_REQ-1:0]       w_granted;
    logic [NUM_REQ-1:0]       w_accept;
    logic [NUM_CDB-1:0]       w_lane_valid;
    logic [c_IDX_W-1:0]       w_lane_src    [NUM_CDB];
    logic [c_IDX_W-1:0]       w_last_idx;
    logic                     w_any_grant;

    // Modular add for requester indices; NUM_REQ need not be a power of two.
    function automatic logic [c_IDX_W-1:0] wrap_add(input logic [c_IDX_W-1:0] base,
                                                    input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ)
            s = s - NUM_REQ;
        return c_IDX_W'(s);
    endfunction

    // Scan from the round-robin pointer and hand out lanes in scan order.
    always_comb begin : p_grant
        int lane;
        lane         = 0;
        w_granted    = '0;
        w_lane_valid = '0;
        w_last_idx   = r_rr_ptr;
        w_any_grant  = 1'b0;
        for (int k = 0; k < NUM_CDB; k++)
            w_lane_src[k] = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!flush && (lane < NUM_CDB) && r_hold_valid[wrap_add(r_rr_ptr, off)]) begin
                w_granted[wrap_add(r_rr_ptr, off)] = 1'b1;
                for (int k = 0; k < NUM_CDB; k++) begin
                    if (lane == k) begin
                        w_lane_valid[k] = 1'b1;
                        w_lane_src[k]   = wrap_add(r_rr_ptr, off);
                    end
                end
                w_last_idx  = wrap_add(r_rr_ptr, off);
                w_any_grant = 1'b1;
                lane        = lane + 1;
            end
        end
    end

    // A granted entry frees its slot in the same cycle, allowing drain-and-refill.
    assign req_ready = {NUM_REQ{~flush}} & (~r_hold_valid | w_granted);
    assign w_accept  = req_valid & req_ready;

    generate
        for (genvar k = 0; k < NUM_CDB; k++) begin : g_lane
            assign cdb_valid[k]                              = w_lane_valid[k];
            assign cdb_src[k*c_IDX_W +: c_IDX_W]             = w_lane_src[k];
            assign cdb_pd_s[k*PHYS_REG_BITS +: PHYS_REG_BITS] =
                w_lane_valid[k] ? r_hold_pd_s[w_lane_src[k]] : '0;
            assign cdb_value[k*32 +: 32]                     =
                w_lane_valid[k] ? r_hold_value[w_lane_src[k]] : '0;
            assign cdb_rob_num[k*ROB_BITS +: ROB_BITS]       =
                w_lane_valid[k] ? r_hold_rob[w_lane_src[k]] : '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_valid <= '0;
            r_rr_ptr     <= '0;
        end else if (flush) begin
            r_hold_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_accept[i])
                    r_hold_valid[i] <= 1'b1;
                else if (w_granted[i])
                    r_hold_valid[i] <= 1'b0;
            end
            if (w_any_grant)
                r_rr_ptr <= wrap_add(w_last_idx, 1);
        end
    end

    // Payload needs no reset: it is only observed while its valid bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_accept[i]) begin
                r_hold_pd_s[i]  <= req_pd_s[i*PHYS_REG_BITS +: PHYS_REG_BITS];
                r_hold_value[i] <= req_value[i*32 +: 32];
                r_hold_rob[i]   <= req_rob_num[i*ROB_BITS +: ROB_BITS];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cdb_writeback_arbiter.sv
// ============================================================================
// Module      : tb_cdb_writeback_arbiter
// Description : Scoreboard bench for cdb_writeback_arbiter (2-lane and 1-lane).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdb_writeback_arbiter;

    typedef struct {
        int          cyc;
        int          lane;
        int          src;
        logic [5:0]  pd;
        logic [31:0] val;
        logic [3:0]  rob;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        flush_1 = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;
    exp_t        q2[$];
    exp_t        q1[$];

    logic [3:0]   req_valid = '0;
    logic [23:0]  req_pd_s = '0;
    logic [127:0] req_value = '0;
    logic [15:0]  req_rob_num = '0;
    logic [3:0]   req_ready;
    logic [1:0]   cdb_valid;
    logic [11:0]  cdb_pd_s;
    logic [63:0]  cdb_value;
    logic [7:0]   cdb_rob_num;
    logic [3:0]   cdb_src;

    logic [3:0]   req_valid_1 = '0;
    logic [23:0]  req_pd_s_1 = '0;
    logic [127:0] req_value_1 = '0;
    logic [15:0]  req_rob_num_1 = '0;
    logic [3:0]   req_ready_1;
    logic [0:0]   cdb_valid_1;
    logic [5:0]   cdb_pd_s_1;
    logic [31:0]  cdb_value_1;
    logic [3:0]   cdb_rob_num_1;
    logic [1:0]   cdb_src_1;

    cdb_writeback_arbiter #(.NUM_REQ(4), .NUM_CDB(2), .PHYS_REG_BITS(6), .ROB_BITS(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_pd_s(req_pd_s), .req_value(req_value),
        .req_rob_num(req_rob_num), .req_ready(req_ready),
        .cdb_valid(cdb_valid), .cdb_pd_s(cdb_pd_s), .cdb_value(cdb_value),
        .cdb_rob_num(cdb_rob_num), .cdb_src(cdb_src)
    );

    cdb_writeback_arbiter #(.NUM_REQ(4), .NUM_CDB(1), .PHYS_REG_BITS(6), .ROB_BITS(4)) dut1 (
        .clk(clk), .rst(rst), .flush(flush_1),
        .req_valid(req_valid_1), .req_pd_s(req_pd_s_1), .req_value(req_value_1),
        .req_rob_num(req_rob_num_1), .req_ready(req_ready_1),
        .cdb_valid(cdb_valid_1), .cdb_pd_s(cdb_pd_s_1), .cdb_value(cdb_value_1),
        .cdb_rob_num(cdb_rob_num_1), .cdb_src(cdb_src_1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int i, input logic [5:0] pd, input logic [31:0] v, input logic [3:0] rob);
        req_valid[i]            = 1'b1;
        req_pd_s[i*6 +: 6]      = pd;
        req_value[i*32 +: 32]   = v;
        req_rob_num[i*4 +: 4]   = rob;
    endtask

    task automatic set_req1(input int i, input logic [5:0] pd, input logic [31:0] v, input logic [3:0] rob);
        req_valid_1[i]          = 1'b1;
        req_pd_s_1[i*6 +: 6]    = pd;
        req_value_1[i*32 +: 32] = v;
        req_rob_num_1[i*4 +: 4] = rob;
    endtask

    task automatic push2(input int c, input int lane, input int src, input logic [5:0] pd,
                         input logic [31:0] v, input logic [3:0] rob);
        exp_t e;
        e = '{cyc: c, lane: lane, src: src, pd: pd, val: v, rob: rob};
        q2.push_back(e);
    endtask

    task automatic push1(input int c, input int src, input logic [5:0] pd,
                         input logic [31:0] v, input logic [3:0] rob);
        exp_t e;
        e = '{cyc: c, lane: 0, src: src, pd: pd, val: v, rob: rob};
        q1.push_back(e);
    endtask

    // Monitors: every broadcast must match the next expected entry, including its cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (cdb_valid[k]) begin
                exp_t e;
                n_checks++;
                if (q2.size() == 0) begin
                    n_err++;
                    $display("FAIL cdb2_unexpected: lane%0d src=%0d pd=%0d val=%h at cyc %0d, expected nothing",
                             k, cdb_src[k*2 +: 2], cdb_pd_s[k*6 +: 6], cdb_value[k*32 +: 32], cyc);
                end else begin
                    e = q2.pop_front();
                    if (e.cyc != cyc || e.lane != k || e.src != int'(cdb_src[k*2 +: 2]) ||
                        e.pd !== cdb_pd_s[k*6 +: 6] || e.val !== cdb_value[k*32 +: 32] ||
                        e.rob !== cdb_rob_num[k*4 +: 4]) begin
                        n_err++;
                        $display("FAIL cdb2_bcast: got cyc=%0d lane=%0d src=%0d pd=%0d val=%h rob=%0d expected cyc=%0d lane=%0d src=%0d pd=%0d val=%h rob=%0d",
                                 cyc, k, cdb_src[k*2 +: 2], cdb_pd_s[k*6 +: 6], cdb_value[k*32 +: 32],
                                 cdb_rob_num[k*4 +: 4], e.cyc, e.lane, e.src, e.pd, e.val, e.rob);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cdb_valid_1[0]) begin
            exp_t e;
            n_checks++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL cdb1_unexpected: src=%0d val=%h at cyc %0d, expected nothing",
                         cdb_src_1, cdb_value_1, cyc);
            end else begin
                e = q1.pop_front();
                if (e.cyc != cyc || e.src != int'(cdb_src_1) || e.pd !== cdb_pd_s_1 ||
                    e.val !== cdb_value_1 || e.rob !== cdb_rob_num_1) begin
                    n_err++;
                    $display("FAIL cdb1_bcast: got cyc=%0d src=%0d pd=%0d val=%h rob=%0d expected cyc=%0d src=%0d pd=%0d val=%h rob=%0d",
                             cyc, cdb_src_1, cdb_pd_s_1, cdb_value_1, cdb_rob_num_1,
                             e.cyc, e.src, e.pd, e.val, e.rob);
                end
            end
        end
    end

    initial begin
        // Reset and idle
        @(negedge clk);
        chk("rst_cdb_valid", 32'(cdb_valid), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'hF);
        chk("rst_req_ready_1", 32'(req_ready_1), 32'hF);
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("idle_cdb_valid", 32'(cdb_valid), 32'h0);
        chk("idle_req_ready", 32'(req_ready), 32'hF);

        // Contention: all four accept together, rr_ptr=0
        tick();
        for (int i = 0; i < 4; i++) set_req(i, 6'(10 + i), 32'h100 + 32'(i), 4'(i));
        push2(cyc + 1, 0, 0, 6'd10, 32'h100, 4'd0);
        push2(cyc + 1, 1, 1, 6'd11, 32'h101, 4'd1);
        push2(cyc + 2, 0, 2, 6'd12, 32'h102, 4'd2);
        push2(cyc + 2, 1, 3, 6'd13, 32'h103, 4'd3);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("contend_valid", 32'(cdb_valid), 32'h3);
        chk("contend_ready", 32'(req_ready), 32'h3);
        tick();
        @(negedge clk);
        chk("contend2_ready", 32'(req_ready), 32'hF);
        tick();
        @(negedge clk);
        chk("contend_drained", 32'(cdb_valid), 32'h0);

        // Single result from FU2
        tick();
        set_req(2, 6'd5, 32'hDEADBEEF, 4'd3);
        push2(cyc + 1, 0, 2, 6'd5, 32'hDEADBEEF, 4'd3);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("single_valid", 32'(cdb_valid), 32'h1);
        chk("single_lane1_src", 32'(cdb_src[3:2]), 32'h0);
        tick();
        @(negedge clk);
        chk("single_gone", 32'(cdb_valid), 32'h0);

        // Back-to-back streaming on FU0
        for (int v = 1; v <= 4; v++) begin
            tick();
            set_req(0, 6'd20, 32'(v), 4'(v));
            push2(cyc + 1, 0, 0, 6'd20, 32'(v), 4'(v));
            @(negedge clk);
            chk("stream_ready0", 32'(req_ready[0]), 32'h1);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("stream_ready0_last", 32'(req_ready[0]), 32'h1);
        tick();
        @(negedge clk);
        chk("stream_drained", 32'(cdb_valid), 32'h0);

        // Flush with FU1/FU2 held; FU3 presented during flush must not be taken
        tick();
        set_req(1, 6'd30, 32'h11, 4'd1);
        set_req(2, 6'd31, 32'h22, 4'd2);
        tick();
        req_valid = '0;
        set_req(3, 6'd33, 32'h33, 4'd3);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_cdb_valid", 32'(cdb_valid), 32'h0);
        chk("flush_req_ready", 32'(req_ready), 32'h0);
        tick();
        flush = 1'b0;
        req_valid = '0;
        set_req(1, 6'd40, 32'h4444, 4'd5);
        push2(cyc + 1, 0, 1, 6'd40, 32'h4444, 4'd5);
        @(negedge clk);
        chk("post_flush_empty", 32'(cdb_valid), 32'h0);
        chk("post_flush_ready", 32'(req_ready), 32'hF);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("post_flush_new", 32'(cdb_valid), 32'h1);
        tick();
        @(negedge clk);
        chk("post_flush_drained", 32'(cdb_valid), 32'h0);

        // Fairness on the single-lane instance: FU0 and FU3 continuously valid
        tick();
        set_req1(0, 6'd50, 32'hA0, 4'd0);
        set_req1(3, 6'd53, 32'hA3, 4'd3);
        push1(cyc + 1, 0, 6'd50, 32'hA0, 4'd0);
        push1(cyc + 2, 3, 6'd53, 32'hA3, 4'd3);
        push1(cyc + 3, 0, 6'd50, 32'hA0, 4'd0);
        push1(cyc + 4, 3, 6'd53, 32'hA3, 4'd3);
        push1(cyc + 5, 0, 6'd50, 32'hA0, 4'd0);
        for (int j = 1; j <= 4; j++) begin
            tick();
            if (j == 4) req_valid_1 = '0;
            @(negedge clk);
            chk("rr1_ready", 32'(req_ready_1), (j % 2 == 1) ? 32'h7 : 32'hE);
        end
        tick();
        @(negedge clk);
        chk("rr1_ready_tail", 32'(req_ready_1), 32'hF);
        tick();
        @(negedge clk);
        chk("rr1_drained", 32'(cdb_valid_1), 32'h0);

        // Asynchronous reset mid-operation drops a held result
        tick();
        set_req(1, 6'd60, 32'h77, 4'd6);
        tick();
        req_valid = '0;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", 32'(cdb_valid), 32'h0);
        chk("async_rst_ready", 32'(req_ready), 32'hF);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("after_rst_valid", 32'(cdb_valid), 32'h0);

        tick();
        tick();
        chk("q2_empty", 32'(q2.size()), 32'h0);
        chk("q1_empty", 32'(q1.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
